bkram_sync: RTL and testbench



---
 rtl/bkram_sync.sv | 220 ++++++++++++++++++++++
 tb/tb_bkram_sync.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bkram_sync.sv
// Backup-RAM sector sequencer: walks sd_lba over the save-RAM image issuing
// sd_rd (load) or sd_wr (save) per sector, with auto-load at the end of a ROM
// download, debounced auto-save after system writes and an optional ack timeout.
module bkram_sync #(
  parameter int unsigned LBA_W           = 32,
  parameter int unsigned SECT_AW         = 8,
  parameter int unsigned AUTOSAVE_CYCLES = 21477270,
  parameter int unsigned ACK_TIMEOUT     = 0
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [23:0]      ram_mask,
  input  logic             dl_active,
  input  logic             img_mounted,
  input  logic             img_readonly,
  input  logic [63:0]      img_size,
  input  logic             load_req,
  input  logic             save_req,
  input  logic             autosave_en,
  input  logic             ram_wr,
  input  logic             sd_ack,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic             bk_ena,
  output logic             loading,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned AS_W    = (AUTOSAVE_CYCLES > 2) ? $clog2(AUTOSAVE_CYCLES) : 1;
  localparam int unsigned AS_LOAD = (AUTOSAVE_CYCLES > 0) ? AUTOSAVE_CYCLES - 1 : 0;
  localparam int unsigned TO_W    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
  localparam int unsigned LBA_LSB = SECT_AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [LBA_W-1:0]  lba_q, lba_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              bk_ena_q, bk_ena_d;
  logic              loading_q, loading_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              dirty_q, dirty_d;
  logic [AS_W-1:0]   timer_q, timer_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic              dl_q, load_req_q, save_req_q, ack_q;

  logic [LBA_W-1:0]  last_lba_c;
  logic              dl_rise_c, dl_fall_c, load_rise_c, save_rise_c;
  logic              ack_rise_c, ack_fall_c, as_fire_c;
  logic              start_load_c, start_save_c;
  logic              unused_mask_c;

  // Sector-offset bits of the mask only set the sector size, not the count.
  assign unused_mask_c = ^ram_mask[LBA_LSB-1:0];
  assign last_lba_c    = LBA_W'(ram_mask[23:LBA_LSB]);

  // Edge detection against last cycle's sampled levels.
  assign dl_rise_c    =  dl_active & ~dl_q;
  assign dl_fall_c    = ~dl_active &  dl_q;
  assign load_rise_c  =  load_req  & ~load_req_q;
  assign save_rise_c  =  save_req  & ~save_req_q;
  assign ack_rise_c   =  sd_ack    & ~ack_q;
  assign ack_fall_c   = ~sd_ack    &  ack_q;
  assign as_fire_c    =  dirty_q & autosave_en & (timer_q == '0);
  assign start_load_c =  dl_fall_c | load_rise_c;
  assign start_save_c =  save_rise_c | as_fire_c;

  // Next-state, sequencing, dirty tracking and image-enable logic.
  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    bk_ena_d  = bk_ena_q;
    loading_d = loading_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    dirty_d   = dirty_q;
    timer_d   = timer_q;
    to_cnt_d  = to_cnt_q;

    if (dl_rise_c) begin
      bk_ena_d = 1'b0;
    end
    if (dl_active && img_mounted && (|img_size) && !img_readonly) begin
      bk_ena_d = 1'b1;
    end

    if ((state_q == S_IDLE) && dirty_q && autosave_en && bk_ena_q && (timer_q != '0)) begin
      timer_d = timer_q - AS_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bk_ena_q && (start_load_c || start_save_c)) begin
          lba_d     = '0;
          rd_d      = start_load_c;
          wr_d      = ~start_load_c;
          loading_d = start_load_c;
          busy_d    = 1'b1;
          to_cnt_d  = '0;
          state_d   = S_REQ;
          if (!start_load_c) begin
            dirty_d = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (ack_rise_c) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_XFER;
        end else if ((ACK_TIMEOUT != 0) && (to_cnt_q == TO_W'(TO_LAST))) begin
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          loading_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_XFER: begin
        if (ack_fall_c) begin
          if (lba_q >= last_lba_c) begin
            loading_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_IDLE;
            if (loading_q) begin
              dirty_d = 1'b0;
            end
          end else begin
            lba_d    = lba_q + LBA_W'(1);
            rd_d     = loading_q;
            wr_d     = ~loading_q;
            to_cnt_d = '0;
            state_d  = S_REQ;
          end
        end
      end
      default: begin
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        loading_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // System writes outside a load mark the image dirty and restart the debounce.
    if (ram_wr && !loading_q) begin
      dirty_d = 1'b1;
      timer_d = AS_W'(AS_LOAD);
    end
  end

  // State and edge-history registers with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      lba_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      bk_ena_q   <= 1'b0;
      loading_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      dirty_q    <= 1'b0;
      timer_q    <= '0;
      to_cnt_q   <= '0;
      dl_q       <= 1'b0;
      load_req_q <= 1'b0;
      save_req_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lba_q      <= lba_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      bk_ena_q   <= bk_ena_d;
      loading_q  <= loading_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      dirty_q    <= dirty_d;
      timer_q    <= timer_d;
      to_cnt_q   <= to_cnt_d;
      dl_q       <= dl_active;
      load_req_q <= load_req;
      save_req_q <= save_req;
      ack_q      <= sd_ack;
    end
  end

  assign sd_lba  = lba_q;
  assign sd_rd   = rd_q;
  assign sd_wr   = wr_q;
  assign bk_ena  = bk_ena_q;
  assign loading = loading_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bkram_sync.sv
// Scoreboard bench for bkram_sync: stimulus pushes expected sector requests,
// done and err pulses; a negedge monitor pops and compares as they appear.
module tb_bkram_sync;

  localparam int unsigned LBA_W  = 32;
  localparam int          AS_CYC = 100;
  localparam int          ACK_TO = 64;
  localparam int          K_RD   = 0;
  localparam int          K_WR   = 1;
  localparam int          K_DONE = 2;
  localparam int          K_ERR  = 3;

  typedef struct {
    int     kind;
    longint lba;
    int     cyc;
  } exp_t;

  logic             clk_sys;
  logic             reset_n;
  logic [23:0]      ram_mask;
  logic             dl_active;
  logic             img_mounted;
  logic             img_readonly;
  logic [63:0]      img_size;
  logic             load_req;
  logic             save_req;
  logic             autosave_en;
  logic             ram_wr;
  logic             sd_ack;
  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             bk_ena;
  logic             loading;
  logic             busy;
  logic             done;
  logic             err;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   req_seen = 0;

  int   hps_mode    = 1;   // 0: never ack, 1: random ack, 2: hold ack at hold_lba
  int   hold_lba    = 0;
  bit   hold_hit    = 1'b0;
  bit   ack_release = 1'b0;

  bkram_sync #(
    .LBA_W          (LBA_W),
    .SECT_AW        (8),
    .AUTOSAVE_CYCLES(AS_CYC),
    .ACK_TIMEOUT    (ACK_TO)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .ram_mask    (ram_mask),
    .dl_active   (dl_active),
    .img_mounted (img_mounted),
    .img_readonly(img_readonly),
    .img_size    (img_size),
    .load_req    (load_req),
    .save_req    (save_req),
    .autosave_en (autosave_en),
    .ram_wr      (ram_wr),
    .sd_ack      (sd_ack),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .bk_ena      (bk_ena),
    .loading     (loading),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input longint lba, input int at);
    exp_t e;
    e.kind = kind;
    e.lba  = lba;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Image of ram_mask+1 bytes in 512-byte sectors, requested in order, then done.
  task automatic push_seq(input bit is_load, input int first_cyc);
    int nsect;
    nsect = (int'(ram_mask) + 1) / 512;
    for (int i = 0; i < nsect; i++) begin
      push_ev(is_load ? K_RD : K_WR, longint'(i), (i == 0) ? first_cyc : -1);
    end
    push_ev(K_DONE, 0, -1);
  endtask

  task automatic sb_check(input int kind);
    exp_t e;
    if (kind == K_RD || kind == K_WR) req_seen++;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: actual kind %0d lba %0d required none at cycle %0d",
               kind, sd_lba, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      if (kind == K_RD || kind == K_WR) chk("sd_lba", 64'(sd_lba), 64'(e.lba));
      if (e.cyc >= 0) chk("event_cycle", 64'(cyc), 64'(e.cyc));
      case (kind)
        K_RD:   begin chk("loading_on_rd", 64'(loading), 1); chk("busy_on_rd", 64'(busy), 1); end
        K_WR:   begin chk("loading_on_wr", 64'(loading), 0); chk("busy_on_wr", 64'(busy), 1); end
        K_DONE: begin chk("busy_on_done", 64'(busy), 0); chk("loading_on_done", 64'(loading), 0); end
        default: begin
          chk("busy_on_err", 64'(busy), 0);
          chk("wr_on_err", 64'(sd_wr), 0);
          chk("done_on_err", 64'(done), 0);
        end
      endcase
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sd_lba"}, 64'(sd_lba), 0);
    chk({tag, "_sd_rd"}, 64'(sd_rd), 0);
    chk({tag, "_sd_wr"}, 64'(sd_wr), 0);
    chk({tag, "_bk_ena"}, 64'(bk_ena), 0);
    chk({tag, "_loading"}, 64'(loading), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_err"}, 64'(err), 0);
  endtask

  task automatic mount(input bit ro);
    @(negedge clk_sys);
    img_readonly = ro;
    img_size     = 64'd8192;
    img_mounted  = 1'b1;
    @(negedge clk_sys);
    img_mounted  = 1'b0;
  endtask

  // Monitor: every new request, done or err cycle consumes one expectation.
  initial begin : monitor
    bit prev_rd;
    bit prev_wr;
    prev_rd = 1'b0;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (reset_n) begin
        if (sd_rd || sd_wr) chk("rd_wr_exclusive", 64'(sd_rd & sd_wr), 0);
        if (sd_rd && !prev_rd) sb_check(K_RD);
        if (sd_wr && !prev_wr) sb_check(K_WR);
        if (done) sb_check(K_DONE);
        if (err) sb_check(K_ERR);
      end
      prev_rd = sd_rd;
      prev_wr = sd_wr;
    end
  end

  // HPS model: acknowledges each sector request after a random delay.
  initial begin : hps
    sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (hps_mode != 0 && reset_n && (sd_rd || sd_wr) && !sd_ack) begin
        repeat ($urandom_range(0, 6)) @(negedge clk_sys);
        sd_ack = 1'b1;
        if (hps_mode == 2 && sd_lba == LBA_W'(hold_lba)) begin
          hold_hit = 1'b1;
          while (!ack_release) @(negedge clk_sys);
          sd_ack   = 1'b0;
          hold_hit = 1'b0;
        end else begin
          repeat ($urandom_range(1, 6)) @(negedge clk_sys);
          sd_ack = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual timeout required completion at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int c;
    int t2;
    int seen0;
    int n;
    reset_n      = 1'b0;
    ram_mask     = '0;
    dl_active    = 1'b0;
    img_mounted  = 1'b0;
    img_readonly = 1'b0;
    img_size     = '0;
    load_req     = 1'b0;
    save_req     = 1'b0;
    autosave_en  = 1'b0;
    ram_wr       = 1'b0;
    idle(3);
    check_all_zero("in_reset");
    reset_n = 1'b1;
    idle(2);
    check_all_zero("after_reset");

    // Auto-load of 16 sectors when the ROM download ends.
    dl_active = 1'b1;
    ram_mask  = 24'h1FFF;
    mount(1'b0);
    chk("bk_ena_mount", 64'(bk_ena), 1);
    idle(2);
    dl_active = 1'b0;
    push_seq(1'b1, cyc + 1);
    drain(3000);
    idle(3);
    chk("loading_after_load", 64'(loading), 0);
    chk("busy_after_load", 64'(busy), 0);

    // User save of 4 sectors.
    ram_mask = 24'h7FF;
    save_req = 1'b1;
    push_seq(1'b0, cyc + 1);
    drain(1000);
    save_req = 1'b0;
    idle(3);

    // User load of 4 sectors.
    load_req = 1'b1;
    push_seq(1'b1, cyc + 1);
    drain(1000);
    load_req = 1'b0;
    idle(3);

    // Simultaneous load and save edges: only the load runs.
    load_req = 1'b1;
    save_req = 1'b1;
    push_seq(1'b1, cyc + 1);
    drain(1000);
    load_req = 1'b0;
    save_req = 1'b0;
    idle(20);

    // A load edge during a save is discarded.
    save_req = 1'b1;
    push_seq(1'b0, cyc + 1);
    idle(3);
    load_req = 1'b1;
    drain(1000);
    load_req = 1'b0;
    save_req = 1'b0;
    idle(20);

    // Auto-save fires AS_CYC+1 cycles after the last write.
    autosave_en = 1'b1;
    ram_wr      = 1'b1;
    idle(1);
    ram_wr      = 1'b0;
    idle(49);
    ram_wr      = 1'b1;
    t2          = cyc;
    push_seq(1'b0, t2 + AS_CYC + 1);
    idle(1);
    ram_wr      = 1'b0;
    drain(1000);
    seen0 = req_seen;
    idle(300);
    chk("no_second_autosave", 64'(req_seen - seen0), 0);

    // Writes during a load are ignored and a completed load leaves nothing dirty.
    load_req = 1'b1;
    push_seq(1'b1, cyc + 1);
    idle(2);
    ram_wr   = 1'b1;
    idle(1);
    ram_wr   = 1'b0;
    drain(1000);
    load_req = 1'b0;
    seen0 = req_seen;
    idle(250);
    chk("no_autosave_after_load", 64'(req_seen - seen0), 0);
    autosave_en = 1'b0;

    // Ack never arrives: request held for ACK_TO cycles, then err.
    hps_mode = 0;
    save_req = 1'b1;
    c = cyc;
    push_ev(K_WR, 0, c + 1);
    push_ev(K_ERR, 0, c + 1 + ACK_TO);
    drain(300);
    idle(5);
    chk("busy_after_timeout", 64'(busy), 0);
    chk("wr_after_timeout", 64'(sd_wr), 0);
    save_req = 1'b0;
    hps_mode = 1;
    idle(5);

    // Read-only image: enable stays low and no requests are issued.
    dl_active = 1'b1;
    mount(1'b1);
    idle(2);
    chk("bk_ena_readonly", 64'(bk_ena), 0);
    seen0 = req_seen;
    dl_active = 1'b0;
    idle(3);
    load_req = 1'b1;
    idle(3);
    save_req = 1'b1;
    idle(3);
    load_req = 1'b0;
    save_req = 1'b0;
    idle(40);
    chk("ro_no_requests", 64'(req_seen - seen0), 0);
    chk("bk_ena_readonly_end", 64'(bk_ena), 0);

    // Reset in the middle of a save, then a fresh save from LBA 0.
    ram_mask  = 24'hFFF;
    dl_active = 1'b1;
    mount(1'b0);
    chk("bk_ena_remount", 64'(bk_ena), 1);
    dl_active = 1'b0;
    push_seq(1'b1, cyc + 1);
    drain(2000);
    idle(3);
    hps_mode = 2;
    hold_lba = 3;
    save_req = 1'b1;
    c = cyc;
    for (int i = 0; i < 4; i++) push_ev(K_WR, longint'(i), (i == 0) ? c + 1 : -1);
    n = 0;
    while (!hold_hit && n < 500) begin
      @(negedge clk_sys);
      n++;
    end
    chk("hold_reached", 64'(hold_hit), 1);
    n = 0;
    while (sd_wr && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    chk("xfer_wr_low", 64'(sd_wr), 0);
    chk("xfer_busy", 64'(busy), 1);
    chk("xfer_lba", 64'(sd_lba), 3);
    chk("pre_reset_events", 64'(exp_q.size()), 0);
    reset_n = 1'b0;
    @(negedge clk_sys);
    check_all_zero("mid_xfer_reset");
    save_req    = 1'b0;
    ack_release = 1'b1;
    idle(3);
    ack_release = 1'b0;
    hps_mode    = 1;
    reset_n     = 1'b1;
    idle(2);
    check_all_zero("post_reset");
    dl_active = 1'b1;
    mount(1'b0);
    idle(1);
    save_req = 1'b1;
    push_seq(1'b0, cyc + 1);
    drain(2000);
    save_req = 1'b0;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
